// File: rtl/idu_stage.sv
// Instruction-decode stage: classifies RISC-V formats, builds the sign-extended immediate,
// and holds up to two decoded entries in a skid buffer. Optional illegal check: IDU_ILLEGAL_EN.
module idu_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rd_wen,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rd_wen;
    logic            illegal;
  } entry_t;

  state_e      state_r;
  logic        in_ready_r;
  logic        out_valid_r;
  entry_t      head_r;
  entry_t      skid_r;
  entry_t      dec_s;
  logic [2:0]  fmt_s;
  logic [31:0] imm32_s;
  logic        legal_s;
  logic        illegal_s;
  logic        accept_s;
  logic        consume_s;

  // Format classification and 32-bit immediate assembly from the opcode.
  always_comb begin
    fmt_s   = FMT_R;
    imm32_s = 32'd0;
    legal_s = 1'b1;
    case (in_inst[6:0])
      OP_REG: fmt_s = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt_s   = FMT_I;
        imm32_s = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        fmt_s   = FMT_S;
        imm32_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        fmt_s   = FMT_B;
        imm32_s = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_s   = FMT_U;
        imm32_s = {in_inst[31:12], 12'h000};
      end
      OP_JAL: begin
        fmt_s   = FMT_J;
        imm32_s = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          fmt_s   = FMT_I;
          imm32_s = {{20{in_inst[31]}}, in_inst[31:20]};
        end else begin
          legal_s = 1'b0;
        end
      end
      OP_REG32: begin
        if (XLEN == 64) begin
          fmt_s = FMT_R;
        end else begin
          legal_s = 1'b0;
        end
      end
      default: legal_s = 1'b0;
    endcase
  end

`ifdef IDU_ILLEGAL_EN
  assign illegal_s = !legal_s || (in_inst[1:0] != 2'b11);
`else
  assign illegal_s = 1'b0;
`endif

  // Pack the decoded bundle; U immediates are sign-extended on RV64 as well.
  always_comb begin
    dec_s         = '0;
    dec_s.pc      = in_pc;
    dec_s.opcode  = in_inst[6:0];
    dec_s.funct3  = in_inst[14:12];
    dec_s.funct7  = in_inst[31:25];
    dec_s.rd      = in_inst[11:7];
    dec_s.rs1     = in_inst[19:15];
    dec_s.rs2     = in_inst[24:20];
    dec_s.imm     = {{(XLEN-31){imm32_s[31]}}, imm32_s[30:0]};
    dec_s.fmt     = fmt_s;
    dec_s.rd_wen  = legal_s && (in_inst[11:7] != 5'd0) &&
                    (fmt_s == FMT_R || fmt_s == FMT_I || fmt_s == FMT_U || fmt_s == FMT_J);
    dec_s.illegal = illegal_s;
  end

  assign accept_s  = in_valid && in_ready_r;
  assign consume_s = out_valid_r && out_ready;

  // Skid-buffer FSM; head_r drives the outputs directly so out_* never depends on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_r      <= '0;
      skid_r      <= '0;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            head_r      <= dec_s;
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_s && consume_s) begin
            head_r <= dec_s;
          end else if (accept_s) begin
            skid_r     <= dec_s;
            state_r    <= ST_TWO;
            in_ready_r <= 1'b0;
          end else if (consume_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_TWO: begin
          if (consume_s) begin
            head_r     <= skid_r;
            state_r    <= ST_ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_pc      = head_r.pc;
  assign out_opcode  = head_r.opcode;
  assign out_funct3  = head_r.funct3;
  assign out_funct7  = head_r.funct7;
  assign out_rd      = head_r.rd;
  assign out_rs1     = head_r.rs1;
  assign out_rs2     = head_r.rs2;
  assign out_imm     = head_r.imm;
  assign out_fmt     = head_r.fmt;
  assign out_rd_wen  = head_r.rd_wen;
  assign out_illegal = head_r.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Randomized bench for idu_stage: an RV32 and an RV64 instance share stimulus and are
// compared against a queue-based reference model of the two-entry buffer.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        in_ready_a, out_valid_a, wen_a, ill_a;
  logic [31:0] pc_a, imm_a;
  logic [6:0]  op_a, f7_a;
  logic [2:0]  f3_a, fmt_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;

  logic        in_ready_b, out_valid_b, wen_b, ill_b;
  logic [63:0] pc_b, imm_b;
  logic [6:0]  op_b, f7_b;
  logic [2:0]  f3_b, fmt_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } item_t;

  item_t q[$];
  int n_vec = 0;
  int n_err = 0;
  logic exp_ill_en;

  always #5 clk = ~clk;

  idu_stage #(.XLEN(32)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(pc_a), .out_opcode(op_a), .out_funct3(f3_a), .out_funct7(f7_a),
    .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a), .out_imm(imm_a), .out_fmt(fmt_a),
    .out_rd_wen(wen_a), .out_illegal(ill_a)
  );

  idu_stage #(.XLEN(64)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(pc_b), .out_opcode(op_b), .out_funct3(f3_b), .out_funct7(f7_b),
    .out_rd(rd_b), .out_rs1(rs1_b), .out_rs2(rs2_b), .out_imm(imm_b), .out_fmt(fmt_b),
    .out_rd_wen(wen_b), .out_illegal(ill_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode computed straight from the ISA field definitions.
  function automatic void exp_decode(input logic [31:0] i, input bit is64,
                                     output logic [2:0] fmt, output logic [63:0] imm,
                                     output logic wen, output logic ill);
    logic legal;
    longint v;
    legal = 1'b1;
    fmt   = 3'd0;
    v     = 0;
    case (i[6:0])
      7'b0110011: fmt = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt = 3'd1; v = longint'($signed(i[31:20]));
      end
      7'b0100011: begin fmt = 3'd2; v = longint'($signed({i[31:25], i[11:7]})); end
      7'b1100011: begin fmt = 3'd3; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'b0110111, 7'b0010111: begin fmt = 3'd4; v = longint'($signed({i[31:12], 12'h000})); end
      7'b1101111: begin fmt = 3'd5; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'b0011011: begin
        if (is64) begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
        else legal = 1'b0;
      end
      7'b0111011: begin
        if (!is64) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    imm = is64 ? 64'(v) : {32'h0, v[31:0]};
    wen = legal && (i[11:7] != 5'd0) && (fmt == 3'd0 || fmt == 3'd1 || fmt == 3'd4 || fmt == 3'd5);
    ill = exp_ill_en && !legal;
  endfunction

  task automatic check_state();
    logic [2:0]  efmt;
    logic [63:0] eimm;
    logic        ewen, eill;
    check("a_in_ready", in_ready_a, q.size() < 2);
    check("b_in_ready", in_ready_b, q.size() < 2);
    check("a_out_valid", out_valid_a, q.size() > 0);
    check("b_out_valid", out_valid_b, q.size() > 0);
    if (q.size() > 0) begin
      exp_decode(q[0].inst, 1'b0, efmt, eimm, ewen, eill);
      check("a_pc", pc_a, q[0].pc[31:0]);
      check("a_opcode", op_a, q[0].inst[6:0]);
      check("a_funct3", f3_a, q[0].inst[14:12]);
      check("a_funct7", f7_a, q[0].inst[31:25]);
      check("a_rd", rd_a, q[0].inst[11:7]);
      check("a_rs1", rs1_a, q[0].inst[19:15]);
      check("a_rs2", rs2_a, q[0].inst[24:20]);
      check("a_imm", imm_a, eimm);
      check("a_fmt", fmt_a, efmt);
      check("a_rd_wen", wen_a, ewen);
      check("a_illegal", ill_a, eill);
      exp_decode(q[0].inst, 1'b1, efmt, eimm, ewen, eill);
      check("b_pc", pc_b, q[0].pc);
      check("b_rd", rd_b, q[0].inst[11:7]);
      check("b_rs1", rs1_b, q[0].inst[19:15]);
      check("b_rs2", rs2_b, q[0].inst[24:20]);
      check("b_opcode", op_b, q[0].inst[6:0]);
      check("b_funct3", f3_b, q[0].inst[14:12]);
      check("b_funct7", f7_b, q[0].inst[31:25]);
      check("b_imm", imm_b, eimm);
      check("b_fmt", fmt_b, efmt);
      check("b_rd_wen", wen_b, ewen);
      check("b_illegal", ill_b, eill);
    end
  endtask

  // One clock of stimulus: check current outputs, clock, then advance the model.
  task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                      input logic ordy, input logic fl);
    bit    acc, con;
    item_t it;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    check_state();
    acc = v && (q.size() < 2) && !fl;
    con = ordy && (q.size() > 0) && !fl;
    it.inst = inst;
    it.pc   = pc;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 13))
      0:  op = 7'b0110011;
      1:  op = 7'b0010011;
      2:  op = 7'b0000011;
      3:  op = 7'b1100111;
      4:  op = 7'b1110011;
      5:  op = 7'b0100011;
      6:  op = 7'b1100011;
      7:  op = 7'b0110111;
      8:  op = 7'b0010111;
      9:  op = 7'b1101111;
      10: op = 7'b0011011;
      11: op = 7'b0111011;
      12: op = r[6:0];
      default: op = 7'b0000000;
    endcase
    return {r[31:7], op};
  endfunction

  function automatic logic [63:0] rand_pc();
    return {$urandom, $urandom};
  endfunction

  initial begin
`ifdef IDU_ILLEGAL_EN
    exp_ill_en = 1'b1;
`else
    exp_ill_en = 1'b0;
`endif
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 64'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_imm_b", imm_b, 64'h0);
    check("rst_pc_b", pc_b, 64'h0);
    check("rst_fields_a", {op_a, f3_a, f7_a, rd_a, rs1_a, rs2_a, fmt_a, wen_a, ill_a}, 64'h0);
    check("rst_fields_b", {op_b, f3_b, f7_b, rd_b, rs1_b, rs2_b, fmt_b, wen_b, ill_b}, 64'h0);

    // addi x1,x0,5 accepted immediately after reset
    step(1'b1, 32'h00500093, 64'h100, 1'b1, 1'b0);
    check("addi_valid", out_valid_a, 1'b1);
    check("addi_fmt", fmt_a, 3'd1);
    check("addi_imm", imm_a, 64'd5);
    check("addi_rd", rd_a, 5'd1);
    check("addi_wen", wen_a, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("addi_drained", out_valid_a, 1'b0);

    // sw x2,-4(x1)
    step(1'b1, 32'hFE20AE23, 64'h104, 1'b1, 1'b0);
    check("sw_fmt", fmt_a, 3'd2);
    check("sw_imm", imm_a, 64'hFFFFFFFC);
    check("sw_rs1", rs1_a, 5'd1);
    check("sw_rs2", rs2_a, 5'd2);
    check("sw_wen", wen_a, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // lui x5,0x80000
    step(1'b1, 32'h800002B7, 64'h108, 1'b1, 1'b0);
    check("lui_imm64", imm_b, 64'hFFFFFFFF80000000);
    check("lui_rd64", rd_b, 5'd5);
    check("lui_fmt64", fmt_b, 3'd4);
    check("lui_imm32", imm_a, 64'h80000000);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Back-pressure: three pushes with out_ready low, then drain
    step(1'b1, 32'h00100113, 64'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 64'h204, 1'b0, 1'b0);
    check("bp_in_ready_low", in_ready_a, 1'b0);
    step(1'b1, 32'h00300213, 64'h208, 1'b0, 1'b0);
    check("bp_held_head", pc_a, 64'h200);
    step(1'b1, 32'h00300213, 64'h208, 1'b1, 1'b0);
    step(1'b1, 32'h00300213, 64'h208, 1'b1, 1'b0);
    check("bp_third_head", pc_a, 64'h208);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Flush in TWO with in_valid high
    step(1'b1, 32'h00400293, 64'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00500313, 64'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00600393, 64'h308, 1'b0, 1'b1);
    check("flush_two_valid", out_valid_a, 1'b0);
    check("flush_two_ready", in_ready_a, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("flush_two_gone", out_valid_b, 1'b0);

    // Flush in ONE with a same-cycle accept and consume
    step(1'b1, 32'h00700413, 64'h400, 1'b1, 1'b0);
    step(1'b1, 32'h00800493, 64'h404, 1'b1, 1'b1);
    check("flush_one_valid", out_valid_a, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Illegal encodings
    step(1'b1, 32'h00000000, 64'h500, 1'b1, 1'b0);
    check("zero_illegal", ill_a, exp_ill_en);
    check("zero_wen", wen_a, 1'b0);
    step(1'b1, 32'h0010009B, 64'h504, 1'b1, 1'b0);
    check("op32_illegal_a", ill_a, exp_ill_en);
    check("op32_illegal_b", ill_b, 1'b0);
    check("op32_fmt_b", fmt_b, 3'd1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 9) < 7, rand_inst(), rand_pc(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    for (int n = 0; n < 3; n++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
